// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the multicycle memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Port index: 0 = core, 1 = auxiliary master.
  typedef logic grant_t;

  localparam int FORMAT_WIDTH = 3;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - next-grant selection for the two requesters
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int CORE_PRIORITY = 1
) (
  input  logic   req0,
  input  logic   req1,
  input  grant_t last_grant,
  output grant_t grant
);

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = (CORE_PRIORITY != 0) ? 1'b0 : ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_mem_arbiter.sv
// rtl/multicycle_mem_arbiter.sv - shares one memory port between core and auxiliary master
module multicycle_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CORE_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    write0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [FORMAT_WIDTH-1:0] format0,
  output logic                    ready0,
  output logic [DATA_WIDTH-1:0]   rdata0,
  output logic                    error0,
  input  logic                    req1,
  input  logic                    write1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  input  logic [FORMAT_WIDTH-1:0] format1,
  output logic                    ready1,
  output logic [DATA_WIDTH-1:0]   rdata1,
  output logic                    error1,
  output logic                    mem_req,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [FORMAT_WIDTH-1:0] mem_format,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Width depends on this instance's parameters, so the request record lives here.
  typedef struct packed {
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [FORMAT_WIDTH-1:0] format;
  } req_t;

  state_t           state;
  grant_t           grant;
  grant_t           last_grant;
  grant_t           next_grant;
  logic [CNT_W-1:0] cnt;
  req_t             req_q;
  req_t             req_port0;
  req_t             req_port1;

  assign req_port0 = '{write: write0, addr: addr0, wdata: wdata0, format: format0};
  assign req_port1 = '{write: write1, addr: addr1, wdata: wdata1, format: format1};

  mem_arb_grant #(
    .CORE_PRIORITY(CORE_PRIORITY)
  ) u_grant (
    .req0      (req0),
    .req1      (req1),
    .last_grant(last_grant),
    .grant     (next_grant)
  );

  // Fields hold while idle; only the store qualifier is gated by mem_req.
  assign mem_write  = mem_req & req_q.write;
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign mem_format = req_q.format;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      req_q      <= '0;
      mem_req    <= 1'b0;
      ready0     <= 1'b0;
      ready1     <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      error0     <= 1'b0;
      error1     <= 1'b0;
    end else begin
      ready0 <= 1'b0;
      ready1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      error0 <= 1'b0;
      error1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant   <= next_grant;
            req_q   <= next_grant ? req_port1 : req_port0;
            cnt     <= '0;
            mem_req <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (grant) begin
              ready1 <= 1'b1;
              rdata1 <= mem_rdata;
            end else begin
              ready0 <= 1'b1;
              rdata0 <= mem_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            // Watchdog expiry: complete with an error and no data.
            mem_req <= 1'b0;
            state   <= DONE;
            if (grant) begin
              ready1 <= 1'b1;
              error1 <= 1'b1;
            end else begin
              ready0 <= 1'b1;
              error0 <= 1'b1;
            end
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_mem_arbiter.sv
// tb/tb_multicycle_mem_arbiter.sv - directed bench for the multicycle memory arbiter
module tb_multicycle_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0, mem_ready = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic [2:0]  format0 = 3'b010, format1 = 3'b010;

  logic        a_ready0, a_ready1, a_error0, a_error1, a_mem_req, a_mem_write;
  logic [31:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata;
  logic [2:0]  a_mem_format;
  logic        b_ready0, b_ready1, b_error0, b_error1, b_mem_req, b_mem_write;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata;
  logic [2:0]  b_mem_format;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multicycle_mem_arbiter #(.CORE_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut_a (
    .clock(clock), .reset(reset),
    .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0), .format0(format0),
    .ready0(a_ready0), .rdata0(a_rdata0), .error0(a_error0),
    .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1), .format1(format1),
    .ready1(a_ready1), .rdata1(a_rdata1), .error1(a_error1),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_format(a_mem_format),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  multicycle_mem_arbiter #(.CORE_PRIORITY(1), .TIMEOUT_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset),
    .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0), .format0(format0),
    .ready0(b_ready0), .rdata0(b_rdata0), .error0(b_error0),
    .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1), .format1(format1),
    .ready1(b_ready1), .rdata1(b_rdata1), .error1(b_error1),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_format(b_mem_format),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        r0, r1, mrdy;
    logic [31:0] mrdata;
    logic        e_req, e_rdy0, e_rdy1;
    logic [31:0] e_rd0, e_rd1, e_addr;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int          n0, nhigh, nseen, rdy_seen;
    logic        got;
    logic [2:0]  seq;

    // Round-robin contention from reset (dut_a), then a single port-0 load.
    //            r0 r1 mrdy mrdata        req rdy0 rdy1 rd0           rd1           addr
    vecs[0]  = '{1, 1, 1, 32'h0,         1, 0, 0, 32'h0,         32'h0,         32'h100};
    vecs[1]  = '{1, 1, 1, 32'h1111_1111, 0, 1, 0, 32'h1111_1111, 32'h0,         32'h100};
    vecs[2]  = '{1, 1, 1, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h100};
    vecs[3]  = '{1, 1, 1, 32'h0,         1, 0, 0, 32'h0,         32'h0,         32'h200};
    vecs[4]  = '{1, 1, 1, 32'h2222_2222, 0, 0, 1, 32'h0,         32'h2222_2222, 32'h200};
    vecs[5]  = '{1, 1, 1, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h200};
    vecs[6]  = '{1, 1, 1, 32'h0,         1, 0, 0, 32'h0,         32'h0,         32'h100};
    vecs[7]  = '{1, 1, 1, 32'h3333_3333, 0, 1, 0, 32'h3333_3333, 32'h0,         32'h100};
    vecs[8]  = '{1, 1, 1, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h100};
    vecs[9]  = '{1, 1, 1, 32'h0,         1, 0, 0, 32'h0,         32'h0,         32'h200};
    vecs[10] = '{1, 1, 1, 32'h4444_4444, 0, 0, 1, 32'h0,         32'h4444_4444, 32'h200};
    vecs[11] = '{0, 0, 1, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h200};
    vecs[12] = '{1, 0, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         32'h100};
    vecs[13] = '{1, 0, 1, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF, 32'h0,         32'h100};
    vecs[14] = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h100};

    addr0 = 32'h100; addr1 = 32'h200; wdata0 = 32'hAAAA_0000; wdata1 = 32'hBBBB_0000;
    step();
    check("rst_mem_req",  {30'b0, a_mem_req, b_mem_req}, 32'h0);
    check("rst_ready",    {28'b0, a_ready0, a_ready1, b_ready0, b_ready1}, 32'h0);
    check("rst_rdata",    a_rdata0 | a_rdata1 | b_rdata0 | b_rdata1, 32'h0);
    check("rst_error",    {28'b0, a_error0, a_error1, b_error0, b_error1}, 32'h0);
    check("rst_mem_addr", a_mem_addr | b_mem_addr, 32'h0);
    check("rst_mem_wdata", a_mem_wdata | b_mem_wdata, 32'h0);
    check("rst_mem_fmt",  {26'b0, a_mem_format, b_mem_format}, 32'h0);
    check("rst_mem_write", {30'b0, a_mem_write, b_mem_write}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrdata;
      step();
      check($sformatf("v%0d_mem_req", i), {31'b0, a_mem_req}, {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_ready0", i), {31'b0, a_ready0}, {31'b0, vecs[i].e_rdy0});
      check($sformatf("v%0d_ready1", i), {31'b0, a_ready1}, {31'b0, vecs[i].e_rdy1});
      check($sformatf("v%0d_rdata0", i), a_rdata0, vecs[i].e_rd0);
      check($sformatf("v%0d_rdata1", i), a_rdata1, vecs[i].e_rd1);
      check($sformatf("v%0d_mem_addr", i), a_mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_error", i), {30'b0, a_error0, a_error1}, 32'h0);
    end

    // Fixed priority (dut_b): port 0 twice, then port 1 once port 0 withdraws.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_0000;
    n0 = 0; nseen = 0; seq = '0;
    for (int c = 0; c < 40 && nseen < 3; c++) begin
      step();
      if (b_ready0) begin
        seq = {seq[1:0], 1'b0}; nseen++; n0++;
        if (n0 == 2) req0 = 1'b0;
      end
      if (b_ready1) begin
        seq = {seq[1:0], 1'b1}; nseen++;
        req1 = 1'b0;
      end
    end
    check("prio_completions", nseen, 3);
    check("prio_order", {29'b0, seq}, 32'h1);

    // Store with wait states (dut_a): fields stable until mem_ready.
    do_reset();
    req1 = 1'b1; write1 = 1'b1; addr1 = 32'h2000; wdata1 = 32'h1234_5678; format1 = 3'b010;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("st%0d_req_write", c), {30'b0, a_mem_req, a_mem_write}, 32'h3);
      check($sformatf("st%0d_addr", c), a_mem_addr, 32'h2000);
      check($sformatf("st%0d_wdata", c), a_mem_wdata, 32'h1234_5678);
      check($sformatf("st%0d_fmt_rdy", c), {28'b0, a_mem_format, a_ready1}, {28'b0, 3'b010, 1'b0});
    end
    mem_ready = 1'b1;
    step();
    check("st_done_ready1", {29'b0, a_ready1, a_error1, a_mem_req}, 32'h4);
    check("st_done_write_gated", {31'b0, a_mem_write}, 32'h0);
    mem_ready = 1'b0; req1 = 1'b0; write1 = 1'b0;
    step();
    check("st_single_pulse", {31'b0, a_ready1}, 32'h0);
    check("st_addr_hold", a_mem_addr, 32'h2000);

    // Watchdog (dut_b, TIMEOUT_CYCLES = 4): mem_ready never comes.
    do_reset();
    req0 = 1'b1; addr0 = 32'h300; mem_rdata = 32'hFFFF_FFFF;
    nhigh = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (b_mem_req) nhigh++;
      if (b_ready0) begin
        got = 1'b1;
        check("to_error0", {31'b0, b_error0}, 32'h1);
        check("to_rdata0", b_rdata0, 32'h0);
      end
    end
    check("to_completed", {31'b0, got}, 32'h1);
    check("to_req_cycles", nhigh, 4);
    req0 = 1'b0;

    // mem_ready in the last allowed cycle wins over the watchdog.
    do_reset();
    req0 = 1'b1;
    repeat (4) step();
    check("to_last_cycle_req", {31'b0, b_mem_req}, 32'h1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    check("to_race_ready0", {30'b0, b_ready0, b_error0}, 32'h2);
    check("to_race_rdata0", b_rdata0, 32'hCAFE_F00D);
    req0 = 1'b0; mem_ready = 1'b0;

    // Asynchronous reset mid-ACCESS (dut_a).
    do_reset();
    req0 = 1'b1; addr0 = 32'h100;
    step(); step();
    check("rm_req_before", {31'b0, a_mem_req}, 32'h1);
    #2 reset = 1'b0;
    #1 check("rm_req_async_drop", {31'b0, a_mem_req}, 32'h0);
    rdy_seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (a_ready0 || a_ready1) rdy_seen++;
    end
    reset = 1'b1; req1 = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    if (a_ready0 || a_ready1) rdy_seen++;
    check("rm_no_ready", rdy_seen, 0);
    check("rm_regrant_port0", {31'b0, a_mem_req}, 32'h1);
    check("rm_regrant_addr", a_mem_addr, 32'h100);
    step();
    check("rm_ready0", {30'b0, a_ready0, a_ready1}, 32'h2);
    req0 = 1'b0; req1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
